layer_out_serializer: RTL and testbench

Output-side stream serializer for the convolution layers. It accepts one wide pixel vector per `Valid_In` pulse from a layer's `Data_Out`/`Valid_Out` and buffers it in a small FIFO. It then emits the pixel one channel word at a time on a ready/valid word stream, with per-pixel and per-frame markers. It sits between a layer such as `Layer2` and the downstream result writer or memory port.

---
 rtl/layer_out_serializer.sv | 170 +++++++++++++++++
 tb/tb_layer_out_serializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: buffers wide pixel vectors coming out of a conv layer
// in a small FIFO and replays each one as a stream of channel words on a
// ready/valid interface, tagging the last word of every pixel and of every
// frame. The layer cannot be stalled, so a full FIFO drops vectors and
// raises a sticky overflow flag.
module layer_out_serializer #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL    = 8,
    parameter int IMG_WIDTH  = 46,
    parameter int IMG_HEIGHT = 46,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Valid_In,
    input  logic [DATA_WIDHT*CHANNEL-1:0]    Data_In,
    output logic [DATA_WIDHT-1:0]            Word_Out,
    output logic                             Word_Valid,
    input  logic                             Word_Ready,
    output logic                             Word_Last_Pixel,
    output logic                             Frame_Last,
    output logic                             Frame_Done,
    output logic                             Overflow,
    output logic [$clog2(FIFO_DEPTH):0]      Fifo_Count
);

    localparam int VEC_W = DATA_WIDHT * CHANNEL;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int CW    = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0]   LAST_CHAN = CW'(CHANNEL - 1);
    localparam logic [XW-1:0]   LAST_COL  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]   LAST_ROW  = YW'(IMG_HEIGHT - 1);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [VEC_W-1:0] fifoMem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [CNTW-1:0]  fifoCount_q;

    logic [0:0]       state_q, state_d;
    logic [VEC_W-1:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic [XW-1:0]    col_q, col_d;
    logic [YW-1:0]    row_q, row_d;
    logic             overflow_q;
    logic             frameDone_q;

    logic sending, handshake, lastChan, frameLast;
    logic fifoEmpty, fifoFull;
    logic popIdle, popSend, pop, push, dropped;

    // Handshake, marker and FIFO push/pop decisions for the current cycle
    always_comb begin
        sending   = (state_q == ST_SEND);
        handshake = sending && Word_Ready;
        lastChan  = sending && (chan_q == LAST_CHAN);
        frameLast = lastChan && (col_q == LAST_COL) && (row_q == LAST_ROW);
        fifoEmpty = (fifoCount_q == '0);
        fifoFull  = (fifoCount_q == DEPTH_CNT);
        popIdle   = (state_q == ST_IDLE) && !fifoEmpty;
        popSend   = handshake && lastChan && !fifoEmpty;
        pop       = popIdle || popSend;
        push      = Valid_In && (!fifoFull || popSend);
        dropped   = Valid_In && fifoFull && !popSend;
    end

    // Serializer next state: load a vector, shift out a word per handshake,
    // and advance the pixel position after the final channel
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        chan_d     = chan_q;
        col_d      = col_q;
        row_d      = row_q;
        case (state_q)
            ST_IDLE: begin
                if (popIdle) begin
                    shiftReg_d = fifoMem[rdPtr_q];
                    chan_d     = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (!lastChan) begin
                        shiftReg_d = shiftReg_q >> DATA_WIDHT;
                        chan_d     = chan_q + 1'b1;
                    end else begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        if (!fifoEmpty) begin
                            shiftReg_d = fifoMem[rdPtr_q];
                            chan_d     = '0;
                        end else begin
                            chan_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers are cleared
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifoMem[wrPtr_q] <= Data_In;
        end
    end

    // Control state, FIFO bookkeeping and sticky/pulse status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shiftReg_q  <= '0;
            chan_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            overflow_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            chan_q     <= chan_d;
            col_q      <= col_d;
            row_q      <= row_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount_q <= fifoCount_q + 1'b1;
                2'b01:   fifoCount_q <= fifoCount_q - 1'b1;
                default: fifoCount_q <= fifoCount_q;
            endcase
            if (dropped) begin
                overflow_q <= 1'b1;
            end
            frameDone_q <= handshake && frameLast;
        end
    end

    // Output drive; the word bus reads zero whenever nothing is offered
    always_comb begin
        Word_Valid      = sending;
        Word_Out        = sending ? shiftReg_q[DATA_WIDHT-1:0] : '0;
        Word_Last_Pixel = lastChan;
        Frame_Last      = frameLast;
        Frame_Done      = frameDone_q;
        Overflow        = overflow_q;
        Fifo_Count      = fifoCount_q;
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed testbench for layer_out_serializer: each scenario task drives its
// own vectors and compares the outputs against hand-derived expectations.
module tb_layer_out_serializer;

    localparam int DW = 32;
    localparam int CH = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int FD = 4;
    localparam int VW = DW * CH;

    logic          clk;
    logic          rst;
    logic          Valid_In;
    logic [VW-1:0] Data_In;
    logic [DW-1:0] Word_Out;
    logic          Word_Valid;
    logic          Word_Ready;
    logic          Word_Last_Pixel;
    logic          Frame_Last;
    logic          Frame_Done;
    logic          Overflow;
    logic [2:0]    Fifo_Count;

    int checks = 0;
    int errors = 0;

    layer_out_serializer #(
        .DATA_WIDHT(DW),
        .CHANNEL   (CH),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Valid_In       (Valid_In),
        .Data_In        (Data_In),
        .Word_Out       (Word_Out),
        .Word_Valid     (Word_Valid),
        .Word_Ready     (Word_Ready),
        .Word_Last_Pixel(Word_Last_Pixel),
        .Frame_Last     (Frame_Last),
        .Frame_Done     (Frame_Done),
        .Overflow       (Overflow),
        .Fifo_Count     (Fifo_Count)
    );

    // Free-running clock, rising edge active
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel k of pixel p carries p*0x1000 + k + 1
    function automatic logic [DW-1:0] expWord(input int p, input int k);
        return DW'(p * 4096 + k + 1);
    endfunction

    function automatic logic [VW-1:0] mkPixel(input int p);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = expWord(p, k);
        return v;
    endfunction

    // Called on a falling edge; leaves the DUT reset and inputs idle
    task automatic doReset();
        rst = 1'b1;
        Valid_In = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Valid_In = 1'b1; Data_In = mkPixel(9); Word_Ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; Valid_In = 1'b0;
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", Word_Valid); end
        checks++; if (Word_Out !== 32'h0) begin errors++; $display("[TB] FAIL reset_word: got %h want 0", Word_Out); end
        checks++; if (Word_Last_Pixel !== 1'b0) begin errors++; $display("[TB] FAIL reset_lastpix: got %b want 0", Word_Last_Pixel); end
        checks++; if (Frame_Last !== 1'b0) begin errors++; $display("[TB] FAIL reset_framelast: got %b want 0", Frame_Last); end
        checks++; if (Frame_Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_framedone: got %b want 0", Frame_Done); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", Overflow); end
        checks++; if (Fifo_Count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", Fifo_Count); end
        @(negedge clk);
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignore_valid: got %b want 0", Word_Valid); end
        checks++; if (Fifo_Count !== 3'd0) begin errors++; $display("[TB] FAIL reset_ignore_count: got %0d want 0", Fifo_Count); end
    endtask

    task automatic test_single_pixel();
        logic expLast;
        doReset();
        Word_Ready = 1'b1; Valid_In = 1'b1; Data_In = mkPixel(0);
        @(negedge clk);
        Valid_In = 1'b0;
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency: got %b want 0", Word_Valid); end
        checks++; if (Fifo_Count !== 3'd1) begin errors++; $display("[TB] FAIL single_count1: got %0d want 1", Fifo_Count); end
        @(negedge clk);
        for (int k = 0; k < CH; k++) begin
            expLast = (k == CH - 1);
            checks++; if (Word_Valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid[%0d]: got %b want 1", k, Word_Valid); end
            checks++; if (Word_Out !== expWord(0, k)) begin errors++; $display("[TB] FAIL single_word[%0d]: got %h want %h", k, Word_Out, expWord(0, k)); end
            checks++; if (Word_Last_Pixel !== expLast) begin errors++; $display("[TB] FAIL single_lastpix[%0d]: got %b want %b", k, Word_Last_Pixel, expLast); end
            @(negedge clk);
        end
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b want 0", Word_Valid); end
        checks++; if (Fifo_Count !== 3'd0) begin errors++; $display("[TB] FAIL single_count0: got %0d want 0", Fifo_Count); end
    endtask

    task automatic test_backpressure();
        int  idx;
        bit  started;
        doReset();
        Word_Ready = 1'b0; Valid_In = 1'b1; Data_In = mkPixel(1);
        @(negedge clk);
        Valid_In = 1'b0;
        idx = 0; started = 1'b0;
        for (int c = 0; c < 40 && idx < CH; c++) begin
            @(negedge clk);
            if (Word_Valid === 1'b1) begin
                started = 1'b1;
                checks++; if (Word_Out !== expWord(1, idx)) begin errors++; $display("[TB] FAIL bp_word[%0d]: got %h want %h", idx, Word_Out, expWord(1, idx)); end
                Word_Ready = ((c % 2) == 1);
                if (Word_Ready) idx++;
            end else if (started) begin
                checks++; errors++;
                $display("[TB] FAIL bp_valid_drop[%0d]: got %b want 1", idx, Word_Valid);
                Word_Ready = 1'b0;
            end else begin
                Word_Ready = 1'b0;
            end
        end
        checks++; if (idx != CH) begin errors++; $display("[TB] FAIL bp_transfers: got %0d want %0d", idx, CH); end
        @(negedge clk);
        Word_Ready = 1'b1;
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got %b want 0", Word_Valid); end
    endtask

    task automatic test_overflow();
        int n;
        logic expLast;
        doReset();
        Word_Ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            if (p == 5) begin
                checks++; if (Fifo_Count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full: got %0d want 4", Fifo_Count); end
                checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b want 0", Overflow); end
            end
            Valid_In = 1'b1; Data_In = mkPixel(10 + p);
            @(negedge clk);
        end
        Valid_In = 1'b0;
        checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b want 1", Overflow); end
        checks++; if (Fifo_Count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d want 4", Fifo_Count); end
        checks++; if (Word_Out !== expWord(10, 0)) begin errors++; $display("[TB] FAIL ovf_hold: got %h want %h", Word_Out, expWord(10, 0)); end
        Word_Ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (Word_Valid === 1'b1) begin
                expLast = ((n % CH) == CH - 1);
                checks++; if (Word_Out !== expWord(10 + n / CH, n % CH)) begin errors++; $display("[TB] FAIL ovf_word[%0d]: got %h want %h", n, Word_Out, expWord(10 + n / CH, n % CH)); end
                checks++; if (Word_Last_Pixel !== expLast) begin errors++; $display("[TB] FAIL ovf_lastpix[%0d]: got %b want %b", n, Word_Last_Pixel, expLast); end
                n++;
            end
        end
        checks++; if (n != 40) begin errors++; $display("[TB] FAIL ovf_words: got %0d want 40", n); end
        @(negedge clk);
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_extra: got %b want 0", Word_Valid); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", Overflow); end
    endtask

    task automatic test_reset_mid_pixel();
        Word_Ready = 1'b1;
        checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_ovf: got %b want 1", Overflow); end
        Valid_In = 1'b1; Data_In = mkPixel(20);
        @(negedge clk);
        Data_In = mkPixel(21);
        @(negedge clk);
        Valid_In = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (Word_Out !== expWord(20, k)) begin errors++; $display("[TB] FAIL rmid_word[%0d]: got %h want %h", k, Word_Out, expWord(20, k)); end
            @(negedge clk);
        end
        rst = 1'b1; Valid_In = 1'b1; Data_In = mkPixel(22);
        @(negedge clk);
        rst = 1'b0; Valid_In = 1'b0;
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b want 0", Word_Valid); end
        checks++; if (Fifo_Count !== 3'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d want 0", Fifo_Count); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ovf: got %b want 0", Overflow); end
        checks++; if (Word_Out !== 32'h0) begin errors++; $display("[TB] FAIL rmid_wordzero: got %h want 0", Word_Out); end
        Valid_In = 1'b1; Data_In = mkPixel(23);
        @(negedge clk);
        Valid_In = 1'b0;
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_latency: got %b want 0", Word_Valid); end
        @(negedge clk);
        for (int k = 0; k < CH; k++) begin
            checks++; if (Word_Out !== expWord(23, k) || Word_Valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_new[%0d]: got %h/%b want %h/1", k, Word_Out, Word_Valid, expWord(23, k)); end
            @(negedge clk);
        end
        checks++; if (Word_Valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle: got %b want 0", Word_Valid); end
    endtask

    task automatic test_full_push_pop();
        int n;
        doReset();
        Word_Ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            Valid_In = 1'b1; Data_In = mkPixel(30 + p);
            @(negedge clk);
        end
        Valid_In = 1'b0;
        checks++; if (Fifo_Count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_full: got %0d want 4", Fifo_Count); end
        Word_Ready = 1'b1;
        for (int k = 0; k < CH; k++) begin
            checks++; if (Word_Out !== expWord(30, k)) begin errors++; $display("[TB] FAIL fpp_word[%0d]: got %h want %h", k, Word_Out, expWord(30, k)); end
            if (k == CH - 1) begin
                checks++; if (Word_Last_Pixel !== 1'b1) begin errors++; $display("[TB] FAIL fpp_lastpix: got %b want 1", Word_Last_Pixel); end
                Valid_In = 1'b1; Data_In = mkPixel(35);
            end
            @(negedge clk);
        end
        Valid_In = 1'b0;
        checks++; if (Fifo_Count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_count: got %0d want 4", Fifo_Count); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_ovf: got %b want 0", Overflow); end
        n = 0;
        for (int c = 0; c < 60 && n < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (Word_Valid === 1'b1) begin
                checks++; if (Word_Out !== expWord(31 + n / CH, n % CH)) begin errors++; $display("[TB] FAIL fpp_drain[%0d]: got %h want %h", n, Word_Out, expWord(31 + n / CH, n % CH)); end
                n++;
            end
        end
        checks++; if (n != 40) begin errors++; $display("[TB] FAIL fpp_words: got %0d want 40", n); end
        @(negedge clk);
        checks++; if (Word_Valid !== 1'b0 || Fifo_Count !== 3'd0) begin errors++; $display("[TB] FAIL fpp_end: got %b/%0d want 0/0", Word_Valid, Fifo_Count); end
    endtask

    task automatic test_frame_wrap();
        int   w;
        logic expFd;
        logic expFl;
        doReset();
        Word_Ready = 1'b1;
        w = 0; expFd = 1'b0;
        for (int c = 0; c < 150; c++) begin
            checks++; if (Frame_Done !== expFd) begin errors++; $display("[TB] FAIL fw_done[c%0d]: got %b want %b", c, Frame_Done, expFd); end
            expFd = 1'b0;
            if (Word_Valid === 1'b1) begin
                w++;
                expFl = (w == 128);
                checks++; if (Word_Out !== expWord(40 + (w - 1) / CH, (w - 1) % CH)) begin errors++; $display("[TB] FAIL fw_word[%0d]: got %h want %h", w, Word_Out, expWord(40 + (w - 1) / CH, (w - 1) % CH)); end
                checks++; if (Frame_Last !== expFl) begin errors++; $display("[TB] FAIL fw_last[%0d]: got %b want %b", w, Frame_Last, expFl); end
                expFd = expFl;
            end
            if ((c % 8) == 0 && (c / 8) < 17) begin
                Valid_In = 1'b1; Data_In = mkPixel(40 + c / 8);
            end else begin
                Valid_In = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (w != 136) begin errors++; $display("[TB] FAIL fw_words: got %0d want 136", w); end
    endtask

    // Bound on total run time in case the DUT wedges a scenario
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; Valid_In = 1'b0; Data_In = '0; Word_Ready = 1'b1;
        $display("[TB] starting layer_out_serializer tests");
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_overflow();
        test_reset_mid_pixel();
        test_full_push_pop();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
